uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised serial frame transmitter and the next-generation serialiser for the link path.
- Accepts one parallel word per valid/ready handshake.
- Serialises it LSB-first as: start bit, DATA_BITS data bits, optional parity bit, 1 or 2 stop bits.
- Each bit is held for CLKS_PER_BIT clocks, so it is baud-rate capable rather than one bit per clock.
- Feeds the pad-side tx line directly; upstream is a host register or FIFO.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, clocks per bit period; legal >= 2.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal 1..2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  word to send; sampled only on handshake.
- tx_valid  input  1  upstream has a word.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- tx  output  1  serial line, registered; idle level 1.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-clock pulse on the final clock of the last stop bit.

Behaviour:
- Reset (async assert) forces: tx=1, tx_ready=1, busy=0, done=0, state=IDLE, all counters 0. A reset mid-frame abandons the frame; no partial frame resumes after release.
- States: IDLE -> START -> DATA -> [PARITY if PARITY_MODE!=0] -> STOP -> IDLE.
- Handshake: accept when tx_valid && tx_ready at a rising edge.
  - On accept: latch tx_data into the shift register, compute the parity bit (even = XOR of the data; odd = inverted XOR), enter START.
  - tx drives 0 from the next clock.
  - tx_valid and tx_data are ignored outside IDLE.
- Bit timing:
  - A baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0.
  - A bit advances when the counter equals CLKS_PER_BIT-1.
  - Counter width is clog2(CLKS_PER_BIT).
- DATA state:
  - Shift right, so tx = shift[0].
  - A bit counter runs 0..DATA_BITS-1; leave DATA when it reaches DATA_BITS-1 and the baud counter wraps.
- STOP state:
  - tx=1 for STOP_BITS*CLKS_PER_BIT clocks.
  - done=1 on the last of those clocks; the next clock is IDLE with tx_ready=1.
- Frame length from accept edge to IDLE = CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS), where P = (PARITY_MODE!=0).
- Back-to-back frames with tx_valid held high: exactly one idle-high clock (the IDLE accept cycle) between the last stop clock and the next start bit. Start-to-start period = frame length + 1.
- tx is glitch-free: driven from a flop, never from combinational state decode.
- Illegal parameter values: elaboration-time error via generate-time check.

Decomposition:
- Package uart_pkg:
  - Parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - Enumerated state type (IDLE, START, DATA, PARITY, STOP).
  - Function returning frame bit count from the parameters.
- One natural sub-module: uart_baud_gen.
  - Parametrised mod-CLKS_PER_BIT counter with synchronous clear.
  - Emits bit_tick on its final value.
  - Cleared on accept so the start bit is exactly CLKS_PER_BIT clocks.
- Shift register, bit counter and FSM live in uart_tx_frame.

Test Plan:
- Basic frame. Config 8N1, CLKS_PER_BIT=4; send 0xA5.
  -> tx sequence per 4-clock bit: 0,1,0,1,0,0,1,0,1,1.
  -> done pulses on clock 40 after accept; tx_ready=0 for clocks 1..40.
- Even parity. Config 8E1; send 0xA5.
  -> parity bit 0; frame 11 bits = 44 clocks.
  -> Same word with odd parity (8O1): parity bit 1.
- Width and stop-bit variation. Config DATA_BITS=7, STOP_BITS=2, 7N2; send 0x55.
  -> 0,1,0,1,0,1,0,1,1,1; 40 clocks; tx high for the final 8 clocks.
- Back-to-back. tx_valid held high with 0x00 then 0xFF (8N1, CLKS_PER_BIT=4).
  -> start bits 41 clocks apart; exactly one idle-high clock between frames; second frame data all 1s.
- Ignore while busy. Pulse tx_valid with 0x3C at clock 12 of a 0xA5 frame.
  -> no handshake; 0xA5 frame unchanged; 0x3C never appears on tx.
- Reset mid-frame. Assert reset_n=0 at clock 17 of a 0xA5 frame.
  -> tx=1, busy=0, done=0 immediately (async).
  -> after release, tx_ready=1 and tx stays 1 until a new handshake.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the serial frame transmitter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Bits on the line for one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity_mode,
                                      input int stop_bits);
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Serial frame transmitter: start, LSB-first data, optional parity, stop bit(s).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
            PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_EVEN ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_tx_frame: illegal parameter value");
        end
    endgenerate

    localparam int BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   bit_tick;
    logic                   baud_clear;

    // Holding the timer at zero in IDLE makes the start bit exactly one period.
    assign baud_clear = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

    // tx_d is the line level for the state being entered, so tx stays a pure flop output.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    shift_d   = tx_data;
                    parity_d  = (PARITY_MODE == PAR_ODD) ? ~(^tx_data) : (^tx_data);
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_MODE != PAR_NONE) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        done      = 1'b1;
                        tx_d      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations driven in parallel against a frame-position model.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int C = 4;
    localparam int DB [4] = '{8, 8, 8, 7};
    localparam int PM [4] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
    localparam int SB [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] tx_w, rdy_w, busy_w, done_w;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_MODE(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_MODE(PAR_ODD), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(C), .PARITY_MODE(PAR_NONE), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data[6:0]), .tx_valid(tx_valid),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // Model: each instance is either idle (pos 0) or at clock pos 1..len of a frame whose
    // line levels are held in fb, one entry per bit period.
    int         pos  [4] = '{0, 0, 0, 0};
    int         flen [4];
    logic [15:0] fb  [4];

    initial for (int i = 0; i < 4; i++) flen[i] = frame_bits(DB[i], PM[i], SB[i]) * C;

    function automatic logic [15:0] build_frame(input int i, input logic [7:0] w);
        logic [15:0] f;
        logic        p;
        p = 1'b0;
        f = '1;
        f[0] = 1'b0;
        for (int k = 0; k < DB[i]; k++) begin
            f[1 + k] = w[k];
            p = p ^ w[k];
        end
        if (PM[i] == PAR_ODD)  f[1 + DB[i]] = ~p;
        if (PM[i] == PAR_EVEN) f[1 + DB[i]] = p;
        return f;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) pos[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pos[i] > 0) begin
                    pos[i] = (pos[i] == flen[i]) ? 0 : pos[i] + 1;
                end else if (tx_valid) begin
                    fb[i]  = build_frame(i, tx_data);
                    pos[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check("tx",    i, 32'(tx_w[i]),   (pos[i] == 0) ? 32'd1 : 32'(fb[i][(pos[i] - 1) / C]));
                check("ready", i, 32'(rdy_w[i]),  32'(pos[i] == 0));
                check("busy",  i, 32'(busy_w[i]), 32'(pos[i] != 0));
                check("done",  i, 32'(done_w[i]), 32'(pos[i] == flen[i]));
            end
        end
    end

    logic [3:0] cap_tx   [0:127];
    logic [3:0] cap_rdy  [0:127];
    logic [3:0] cap_done [0:127];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_pulse(input logic [7:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Samples n clocks after an accept edge (clock 1 = first clock after the edge).
    // kind 1: pulse tx_valid with 0x3C during clock inj; kind 2: reset at clock inj for 3 clocks;
    // kind 3: drop tx_valid at clock inj.
    task automatic capture(input int n, input int inj, input int kind);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            cap_tx[k]   = tx_w;
            cap_rdy[k]  = rdy_w;
            cap_done[k] = done_w;
            if (kind == 1 && k == inj)     begin tx_data = 8'h3C; tx_valid = 1'b1; end
            if (kind == 1 && k == inj + 1) tx_valid = 1'b0;
            if (kind == 3 && k == inj)     tx_valid = 1'b0;
            if (kind == 2 && k == inj) begin
                #1 reset_n = 1'b0;
                #1;
                for (int i = 0; i < 4; i++) begin
                    check("rst_async_tx",   i, 32'(tx_w[i]),   32'd1);
                    check("rst_async_busy", i, 32'(busy_w[i]), 32'd0);
                    check("rst_async_done", i, 32'(done_w[i]), 32'd0);
                end
            end
            if (kind == 2 && k == inj + 3) #1 reset_n = 1'b1;
        end
    endtask

    function automatic int first_done(input int i, input int n);
        for (int k = 1; k <= n; k++) if (cap_done[k][i]) return k;
        return -1;
    endfunction

    logic [9:0] exp_a5_8n1;
    logic [9:0] exp_55_7n2;
    int cnt;
    int start2;

    initial begin
        exp_a5_8n1 = 10'b1101001010;
        exp_55_7n2 = 10'b1110101010;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            check("reset_tx",    i, 32'(tx_w[i]),   32'd1);
            check("reset_ready", i, 32'(rdy_w[i]),  32'd1);
            check("reset_busy",  i, 32'(busy_w[i]), 32'd0);
            check("reset_done",  i, 32'(done_w[i]), 32'd0);
        end
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (3) tick();

        // Basic frame 0xA5 on all configs; parity bit is the 10th period.
        send_pulse(8'hA5);
        capture(60, 0, 0);
        for (int b = 0; b < 10; b++) check("8n1_a5_bit", 0, 32'(cap_tx[b * C + 2][0]), 32'(exp_a5_8n1[b]));
        check("8n1_done_clk", 0, first_done(0, 60), 40);
        check("8e1_done_clk", 1, first_done(1, 60), 44);
        check("8e1_parity",   1, 32'(cap_tx[9 * C + 2][1]), 32'd0);
        check("8o1_parity",   2, 32'(cap_tx[9 * C + 2][2]), 32'd1);
        cnt = 0;
        for (int k = 1; k <= 60; k++) if (!cap_rdy[k][0]) cnt++;
        check("8n1_notready_clks", 0, cnt, 40);
        check("8n1_ready_clk1", 0, 32'(cap_rdy[1][0]), 32'd0);
        tick();

        // 7N2 with 0x55.
        send_pulse(8'h55);
        capture(60, 0, 0);
        for (int b = 0; b < 10; b++) check("7n2_55_bit", 3, 32'(cap_tx[b * C + 2][3]), 32'(exp_55_7n2[b]));
        check("7n2_done_clk", 3, first_done(3, 60), 40);
        cnt = 0;
        for (int k = 33; k <= 40; k++) if (cap_tx[k][3]) cnt++;
        check("7n2_stop_high", 3, cnt, 8);
        tick();

        // tx_valid pulsed with 0x3C during clock 12 must be ignored.
        send_pulse(8'hA5);
        capture(60, 12, 1);
        for (int b = 0; b < 10; b++) check("busy_ignore_bit", 0, 32'(cap_tx[b * C + 2][0]), 32'(exp_a5_8n1[b]));
        check("busy_ignore_done", 0, first_done(0, 60), 40);
        tick();

        // Back-to-back: 0x00 then 0xFF with tx_valid held high.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_data  = 8'hFF;
        capture(100, 50, 3);
        start2 = -1;
        for (int k = 2; k <= 100; k++)
            if (start2 < 0 && cap_tx[k][0] == 1'b0 && cap_tx[k - 1][0] == 1'b1) start2 = k;
        check("b2b_start_gap", 0, start2 - 1, 41);
        cnt = 0;
        for (int k = 1; k < 42; k++) if (cap_rdy[k][0]) cnt++;
        check("b2b_idle_clks", 0, cnt, 1);
        check("b2b_idle_high", 0, 32'(cap_tx[41][0]), 32'd1);
        cnt = 0;
        for (int k = 46; k <= 77; k++) if (cap_tx[k][0]) cnt++;
        check("b2b_ff_data", 0, cnt, 32);
        repeat (5) tick();

        // Reset at clock 17 of an 0xA5 frame, released three clocks later.
        send_pulse(8'hA5);
        capture(40, 17, 2);
        check("pre_reset_tx", 0, 32'(cap_tx[17][0]), 32'd0);
        cnt = 0;
        for (int k = 21; k <= 40; k++) if (cap_tx[k][0] && cap_rdy[k][0]) cnt++;
        check("post_reset_idle", 0, cnt, 20);
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
